// File: rtl/pid_channel_scheduler.sv
// pid_channel_scheduler
// Shares one PID multiply/accumulate path across NCH motor channels.
// A free-running tick counter starts a sweep. At sweep start the scheduler
// snapshots every encoder value, every setpoint and the live gains. It then
// steps each channel through ERR, MP, MI, MD and WB, and pulses done.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   enc_flat [NCH*N]    signed encoder values, channel c at [c*N +: N]
//   set_flat [NCH*N]    signed setpoints, same packing
//   cfg_we/addr/data    gain write port (0=kp, 1=ki, 2=kd, 3=ignored)
//   pwm_flat [NCH*N]    saturated PWM per channel, same packing
//   busy                high while channels are being processed
//   done                one-cycle pulse at the end of a sweep
//   overrun             sticky, set when a tick arrives outside IDLE
//
// Optional build macro ANTIWINDUP_EN: when defined, the saturated PWM value
// is stored back into the integrator history in place of the raw accumulator.
module pid_channel_scheduler #(
  parameter int N        = 8,
  parameter int NCH      = 4,
  parameter int TICK_MAX = 55609,
  parameter int PWM_MAX  = 127
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH*N-1:0] enc_flat,
  input  logic [NCH*N-1:0] set_flat,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [7:0]       cfg_data,
  output logic [NCH*N-1:0] pwm_flat,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam logic signed [31:0] PWM_LIM = 32'(PWM_MAX);

  typedef enum logic [2:0] {IDLE, ERR, MP, MI, MD, WB, DONE} state_t;

  state_t state, state_nxt;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [CW-1:0] ch;
  logic          last_ch;

  logic signed [7:0]  kp_live, ki_live, kd_live;
  logic signed [31:0] kp_w, ki_w, kd_w;
  logic signed [31:0] tgt [NCH];
  logic signed [31:0] act [NCH];
  logic signed [31:0] err, acc;
  logic signed [31:0] op_a, op_b, prod;

  logic signed [31:0] hist_acc [NCH];
  logic signed [31:0] e1 [NCH];
  logic signed [31:0] e2 [NCH];
  logic [N-1:0]       pwm [NCH];

  function automatic logic signed [31:0] sext_n(input logic [N-1:0] v);
    return {{(32-N){v[N-1]}}, v};
  endfunction

  function automatic logic signed [31:0] sext_8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  // Clamp the accumulator into the unsigned PWM range 0..PWM_MAX.
  function automatic logic [N-1:0] sat_pwm(input logic signed [31:0] a);
    if (a < 0)
      return '0;
    else if (a > PWM_LIM)
      return PWM_LIM[N-1:0];
    else
      return a[N-1:0];
  endfunction

  // Control tick: counter wraps after TICK_MAX, tick marks the terminal count.
  assign tick = (tick_cnt == TW'(TICK_MAX));

  always_ff @(posedge clk) begin
    if (!rst_n)
      tick_cnt <= '0;
    else if (tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 1'b1;
  end

  // Live gain registers. The sweep runs on its own copies, so writes here
  // only affect the next sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kp_live <= 8'sd17;
      ki_live <= 8'sd14;
      kd_live <= 8'sd0;
    end else if (cfg_we) begin
      case (cfg_addr)
        2'd0:    kp_live <= cfg_data;
        2'd1:    ki_live <= cfg_data;
        2'd2:    kd_live <= cfg_data;
        default: ;
      endcase
    end
  end

  assign last_ch = (ch == CW'(NCH - 1));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (tick) state_nxt = ERR;
      ERR:  begin busy = 1'b1; state_nxt = MP; end
      MP:   begin busy = 1'b1; state_nxt = MI; end
      MI:   begin busy = 1'b1; state_nxt = MD; end
      MD:   begin busy = 1'b1; state_nxt = WB; end
      WB:   begin busy = 1'b1; state_nxt = last_ch ? DONE : ERR; end
      DONE: begin done = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  // Shared multiplier: operand pair chosen by the current term.
  always_comb begin
    op_a = kp_w;
    op_b = err;
    case (state)
      MI:      begin op_a = ki_w; op_b = e1[ch]; end
      MD:      begin op_a = kd_w; op_b = e2[ch]; end
      default: ;
    endcase
  end

  assign prod = op_a * op_b;

  // Control state, per-channel history and PWM outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ch      <= '0;
      overrun <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        hist_acc[c] <= '0;
        e1[c]       <= '0;
        e2[c]       <= '0;
        pwm[c]      <= '0;
      end
    end else begin
      state <= state_nxt;
      if (tick && state != IDLE)
        overrun <= 1'b1;
      if (state == IDLE && tick)
        ch <= '0;
      if (state == WB) begin
        e2[ch]  <= e1[ch];
        e1[ch]  <= err;
        pwm[ch] <= sat_pwm(acc);
`ifdef ANTIWINDUP_EN
        hist_acc[ch] <= {{(32-N){1'b0}}, sat_pwm(acc)};
`else
        hist_acc[ch] <= acc;
`endif
        if (!last_ch)
          ch <= ch + 1'b1;
      end
    end
  end

  // Snapshot and arithmetic datapath. These registers are always loaded
  // before use within a sweep, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && tick) begin
      for (int c = 0; c < NCH; c++) begin
        tgt[c] <= sext_n(set_flat[c*N +: N]);
        act[c] <= sext_n(enc_flat[c*N +: N]);
      end
      kp_w <= sext_8(kp_live);
      ki_w <= sext_8(ki_live);
      kd_w <= sext_8(kd_live);
    end
    case (state)
      ERR:     err <= tgt[ch] - act[ch];
      MP:      acc <= hist_acc[ch] + prod;
      MI:      acc <= acc - prod;
      MD:      acc <= acc + prod;
      default: ;
    endcase
  end

  for (genvar g = 0; g < NCH; g++) begin : g_pwm
    assign pwm_flat[g*N +: N] = pwm[g];
  end

endmodule

// File: doc/pid_channel_scheduler.md
Name: pid_channel_scheduler

Overview:
Time-multiplexes one shared PID arithmetic path across NCH motor channels. Generates the control tick, snapshots all encoder and setpoint values, then steps through the channels in sequence. Holds per-channel history (accumulator, two previous errors) and exposes a saturated PWM value per channel. Sits between the encoder/setpoint registers and the per-motor PWM generators.

Parameters:
N, 8, width of encoder, setpoint and PWM words; two's-complement inputs.
NCH, 4, number of motor channels.
TICK_MAX, 55609, tick counter terminal value; tick period is TICK_MAX+1 clocks (1.5 ms).
PWM_MAX, 127, upper saturation limit of PWM outputs.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
enc_flat  in  NCH*N  signed encoder values; channel c at [c*N +: N]
set_flat  in  NCH*N  signed setpoints; same packing
cfg_we  in  1  gain write strobe
cfg_addr  in  2  0=kp, 1=ki, 2=kd, 3=ignored
cfg_data  in  8  signed gain value
pwm_flat  out  NCH*N  unsigned PWM per channel; same packing
busy  out  1  high while a sweep is in progress
done  out  1  one-cycle pulse at end of sweep
overrun  out  1  sticky: tick arrived while sweep still running

Behaviour:
- Reset (rst_n=0 at clk edge): tick counter=0, FSM=IDLE, pwm_flat=0, busy=0, done=0, overrun=0; all acc/e1/e2 history=0; gain regs kp=17, ki=14, kd=0. Reset mid-sweep aborts the sweep; no partial writeback.
- Tick counter: 0..TICK_MAX, wraps to 0. tick=1 for the single cycle where counter==TICK_MAX.
- Config: cfg_we writes the live gain reg on the same edge. Working gains are copied from the live regs at sweep start, so writes during a sweep affect the next sweep only.
- FSM states: IDLE, ERR, MP, MI, MD, WB, DONE.
- IDLE & tick: snapshot all enc/set (sign-extended to 32 bits) and gains; ch=0; go to ERR.
- ERR: err = target[ch] - actual[ch] (32-bit signed).
- MP: acc = hist_acc[ch] + kp*err.
- MI: acc = acc - ki*e1[ch].
- MD: acc = acc + kd*e2[ch].
- WB: e2[ch]<=e1[ch]; e1[ch]<=err; hist_acc[ch]<=acc (see optional feature). pwm[ch]<=0 if acc<0; PWM_MAX if acc>PWM_MAX; else acc[N-1:0]. If ch==NCH-1, go to DONE; else ch++ and go to ERR.
- DONE: done=1 for this cycle; next state IDLE.
- busy=1 in ERR..WB, 0 in IDLE and DONE. Sweep length is 5*NCH cycles plus 1 DONE cycle (21 for NCH=4).
- Arithmetic: gains are sign-extended 8→32; all products and sums are 32-bit signed and wrap on overflow (no trap).
- Channels other than ch hold their pwm values. Every pwm changes only on its WB edge.
- Tick while not IDLE (including DONE): tick ignored, overrun<=1. Cleared only by reset.
- Tick coincident with reset: reset wins.

Optional Feature:
ANTIWINDUP_EN. When defined, WB stores the saturated value (0..PWM_MAX, zero-extended) into hist_acc[ch]. When undefined, hist_acc[ch] stores the raw 32-bit acc.

Test Plan:
- TICK_MAX=99, defaults, ch0 set=3 enc=0: sweep 1 gives pwm0=51; sweep 2 gives pwm0=60 (51+51-42). Other channels (set=enc=0) stay 0. done pulses 21 cycles after tick; busy high for 20.
- ch1 set=0 enc=8'hFB (-5): err=5, pwm1=85 (checks sign extension).
- ch2 set=0 enc=5, two sweeps: pwm2=0 both times. hist_acc2 is -85 then -100 without ANTIWINDUP_EN; 0 then 0 with it (second sweep acc=-15).
- ch3 set=10 enc=0: acc=170, pwm3=127 (PWM_MAX clamp). Write kp=1 mid-sweep: current sweep still uses 17, next sweep uses 1.
- Force a tick while busy (TICK_MAX < 21, e.g. 15): overrun=1 and stays set; the sweep in progress completes normally.
- Assert rst_n=0 during MI of ch2: next cycle all pwm=0, busy=0, gains 17/14/0. A sweep after release reproduces the sweep-1 values.
